// File: rtl/key_evt_pkg.sv
// Shared constants for the key event decoder: FSM state encodings and
// default timing for a 50 MHz clock.
package key_evt_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HELD  = 3'd1;
  localparam logic [2:0] ST_WAIT2 = 3'd2;
  localparam logic [2:0] ST_HELD2 = 3'd3;
  localparam logic [2:0] ST_LONG  = 3'd4;

  localparam int unsigned DEF_LONG_TIME   = 50_000_000;
  localparam int unsigned DEF_DBL_GAP     = 15_000_000;
  localparam int unsigned DEF_REL_TIME    = 1_000_000;
  localparam int unsigned DEF_REPEAT_TIME = 10_000_000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// One key: input synchronizer, release qualifier, click/double/long FSM and
// registered event pulses. Define KEY_REPEAT_EN for auto-repeat while held long.
module key_event_fsm
  import key_evt_pkg::*;
#(
  parameter int unsigned LONG_TIME   = DEF_LONG_TIME,
  parameter int unsigned DBL_GAP     = DEF_DBL_GAP,
  parameter int unsigned REL_TIME    = DEF_REL_TIME,
  parameter int unsigned REPEAT_TIME = DEF_REPEAT_TIME
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  input  logic       key_down,
  output logic       click,
  output logic       dbl_click,
  output logic       long_press,
  output logic [2:0] state
);

  // One counter serves every interval, so it is sized for the longest one.
  localparam int unsigned CNT_MAX = max3(LONG_TIME, DBL_GAP, REPEAT_TIME);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW = $clog2(REL_TIME + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TIME - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_GAP - 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(REL_TIME);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TIME - 1);
`endif

  logic [1:0]    sync;
  logic [RW-1:0] rel_cnt;
  logic          rel;
  logic [CW-1:0] cnt;

  // Reset to all-ones so a key is considered up until proven otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rel_cnt <= '0;
    else if (!sync[1])          rel_cnt <= '0;
    else if (rel_cnt != REL_LAST) rel_cnt <= rel_cnt + RW'(1);
  end

  assign rel = (rel_cnt == REL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_down) begin
            state <= ST_HELD;
            cnt   <= '0;
          end
        end
        // Long-press timeout outranks a coincident release.
        ST_HELD: begin
          if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= ST_LONG;
            cnt        <= '0;
          end else if (rel) begin
            state <= ST_WAIT2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // A second press outranks a coincident gap expiry.
        ST_WAIT2: begin
          if (key_down) begin
            dbl_click <= 1'b1;
            state     <= ST_HELD2;
          end else if (cnt == DBL_LAST) begin
            click <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HELD2: begin
          if (rel) state <= ST_IDLE;
        end
        ST_LONG: begin
          if (rel) begin
            state <= ST_IDLE;
          end
`ifdef KEY_REPEAT_EN
          else if (cnt == REP_LAST) begin
            long_press <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Per-key click / double-click / long-press classifier over KEY_W independent
// keys. Define KEY_REPEAT_EN to re-pulse long_press while a key stays held.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int unsigned KEY_W       = 2,
  parameter int unsigned LONG_TIME   = DEF_LONG_TIME,
  parameter int unsigned DBL_GAP     = DEF_DBL_GAP,
  parameter int unsigned REL_TIME    = DEF_REL_TIME,
  parameter int unsigned REPEAT_TIME = DEF_REPEAT_TIME
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_W-1:0]   key_in,
  input  logic [KEY_W-1:0]   key_down,
  output logic [KEY_W-1:0]   click,
  output logic [KEY_W-1:0]   dbl_click,
  output logic [KEY_W-1:0]   long_press,
  output logic [3*KEY_W-1:0] dbg_state
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    key_event_fsm #(
      .LONG_TIME  (LONG_TIME),
      .DBL_GAP    (DBL_GAP),
      .REL_TIME   (REL_TIME),
      .REPEAT_TIME(REPEAT_TIME)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in[i]),
      .key_down  (key_down[i]),
      .click     (click[i]),
      .dbl_click (dbl_click[i]),
      .long_press(long_press[i]),
      .state     (dbg_state[3*i +: 3])
    );
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timing parameters.
module tb_key_event_decoder;
  import key_evt_pkg::*;

  localparam int LT = 100;
  localparam int DG = 40;
  localparam int RT = 5;
  localparam int RP = 20;
`ifdef KEY_REPEAT_EN
  localparam int EXP_LONG_N    = 3;
  localparam int EXP_LONG_LAST = 140;
`else
  localparam int EXP_LONG_N    = 1;
  localparam int EXP_LONG_LAST = 100;
`endif
  // Release edge to click pulse: 2 sync + RT qualify + 1 transition + DG gap.
  localparam int CLICK_LAT = 2 + RT + 1 + DG;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_in;
  logic [1:0] key_down;
  logic [1:0] click;
  logic [1:0] dbl_click;
  logic [1:0] long_press;
  logic [5:0] dbg_state;

  key_event_decoder #(
    .KEY_W(2), .LONG_TIME(LT), .DBL_GAP(DG), .REL_TIME(RT), .REPEAT_TIME(RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_down  (key_down),
    .click     (click),
    .dbl_click (dbl_click),
    .long_press(long_press),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int multi_err = 0;
  int n_click[2], n_dbl[2], n_long[2];
  int c_click[2], c_dbl[2], c_long_first[2], c_long_last[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      n_click[k] = 0; n_dbl[k] = 0; n_long[k] = 0;
      c_click[k] = -1; c_dbl[k] = -1; c_long_first[k] = -1; c_long_last[k] = -1;
    end
  endtask

  // Advance n cycles, logging pulses on each falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (click[k] === 1'b1) begin n_click[k]++; c_click[k] = cyc; end
        if (dbl_click[k] === 1'b1) begin n_dbl[k]++; c_dbl[k] = cyc; end
        if (long_press[k] === 1'b1) begin
          if (n_long[k] == 0) c_long_first[k] = cyc;
          n_long[k]++;
          c_long_last[k] = cyc;
        end
        if (int'(click[k]) + int'(dbl_click[k]) + int'(long_press[k]) > 1) multi_err++;
      end
    end
  endtask

  task automatic press(input logic [1:0] m, output int pc);
    key_down = m;
    step(1);
    key_down = 2'b00;
    pc = cyc;
  endtask

  int pc;
  int rel_at;

  initial begin
    rst_n    = 1'b0;
    key_in   = 2'b11;
    key_down = 2'b00;
    clear_mon();
    step(3);
    chk("reset_outputs", {26'd0, click, dbl_click, long_press}, 32'd0);
    chk("reset_state", {26'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    step(10);

    // 1: short press -> single click
    clear_mon();
    key_in[0] = 1'b0; step(4);
    press(2'b01, pc);
    step(29);
    key_in[0] = 1'b1; rel_at = cyc;
    step(60);
    chk("t1_click_n", n_click[0], 1);
    chk("t1_click_cyc", c_click[0], rel_at + CLICK_LAT);
    chk("t1_dbl_n", n_dbl[0], 0);
    chk("t1_long_n", n_long[0], 0);

    // 2: double click, then long hold in HELD2
    clear_mon();
    key_in[0] = 1'b0; step(4);
    press(2'b01, pc);
    step(10);
    key_in[0] = 1'b1; step(20);
    key_in[0] = 1'b0; step(4);
    press(2'b01, pc);
    step(200);
    chk("t2_dbl_n", n_dbl[0], 1);
    chk("t2_dbl_cyc", c_dbl[0], pc);
    chk("t2_long_in_held2", n_long[0], 0);
    key_in[0] = 1'b1; step(60);
    chk("t2_click_n", n_click[0], 0);
    chk("t2_state_idle", {29'd0, dbg_state[2:0]}, {29'd0, ST_IDLE});

    // 3: long press
    clear_mon();
    key_in[0] = 1'b0; step(4);
    press(2'b01, pc);
    step(150);
    chk("t3_long_first", c_long_first[0], pc + 100);
    chk("t3_long_last", c_long_last[0], pc + EXP_LONG_LAST);
    key_in[0] = 1'b1; step(60);
    chk("t3_long_n", n_long[0], EXP_LONG_N);
    chk("t3_click_n", n_click[0], 0);
    chk("t3_dbl_n", n_dbl[0], 0);

    // 4: bouncing release
    clear_mon();
    key_in[0] = 1'b0; step(4);
    press(2'b01, pc);
    step(10);
    repeat (5) begin
      key_in[0] = 1'b1; step(3);
      key_in[0] = 1'b0; step(1);
    end
    chk("t4_still_held", {29'd0, dbg_state[2:0]}, {29'd0, ST_HELD});
    key_in[0] = 1'b1; rel_at = cyc;
    step(60);
    chk("t4_click_n", n_click[0], 1);
    chk("t4_click_cyc", c_click[0], rel_at + CLICK_LAT);
    chk("t4_dbl_n", n_dbl[0], 0);

    // 5a: second press on the last gap cycle
    clear_mon();
    key_in[0] = 1'b0; step(4);
    press(2'b01, pc);
    step(10);
    key_in[0] = 1'b1; rel_at = cyc;
    step(40);
    key_in[0] = 1'b0; step(7);
    press(2'b01, pc);
    chk("t5_press_on_gap_edge", pc, rel_at + CLICK_LAT);
    chk("t5_dbl_cyc", c_dbl[0], pc);
    step(10);
    key_in[0] = 1'b1; step(60);
    chk("t5_dbl_n", n_dbl[0], 1);
    chk("t5_click_n", n_click[0], 0);

    // 5b: both keys clicked together
    clear_mon();
    key_in = 2'b00; step(4);
    press(2'b11, pc);
    step(10);
    key_in = 2'b11; rel_at = cyc;
    step(60);
    chk("t5b_click0_n", n_click[0], 1);
    chk("t5b_click1_n", n_click[1], 1);
    chk("t5b_click0_cyc", c_click[0], rel_at + CLICK_LAT);
    chk("t5b_click1_cyc", c_click[1], rel_at + CLICK_LAT);

    // 6: reset while held
    clear_mon();
    key_in[0] = 1'b0; step(4);
    press(2'b01, pc);
    step(49);
    chk("t6_pre_reset_held", {29'd0, dbg_state[2:0]}, {29'd0, ST_HELD});
    rst_n = 1'b0;
    #1;
    chk("t6_reset_state", {26'd0, dbg_state}, 32'd0);
    chk("t6_reset_outputs", {26'd0, click, dbl_click, long_press}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("t6_no_pulse_on_abort", n_long[0] + n_click[0] + n_dbl[0], 0);
    press(2'b01, pc);
    step(110);
    chk("t6_long_n", n_long[0], 1);
    chk("t6_long_first", c_long_first[0], pc + 100);
    key_in[0] = 1'b1; step(60);
    chk("t6_click_n", n_click[0], 0);

    chk("one_event_per_key", multi_err, 0);
    chk("final_state_idle", {26'd0, dbg_state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
